crab_mem_arbiter: RTL
=====================

Name: crab_mem_arbiter

Overview:
Shares the core's single memory port between two requesters: the instruction-fetch unit (IF, read-only) and the load/store unit (LS, read/write). It accepts one request at a time over a valid/ready handshake and drives the downstream memory interface. It holds that interface stable until mem_ready, then returns data or an error to the granted requester. A timeout watchdog turns a stalled memory into an error response instead of a core hang.

Parameters:
XLEN, 32, address/data width
ARB_MODE, 0, 0 = round-robin between IF and LS; 1 = fixed LS priority
TIMEOUT_CYCLES, 64, BUSY cycles without mem_ready before an error response; 0 disables the watchdog

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req_valid  in  1  IF request present
if_req_ready  out  1  IF request accepted this cycle (combinational)
if_req_addr  in  XLEN  fetch address
if_resp_valid  out  1  one-cycle IF response pulse
if_resp_rdata  out  XLEN  fetched word
if_resp_err  out  1  IF access timed out
ls_req_valid  in  1  LS request present
ls_req_ready  out  1  LS request accepted this cycle (combinational)
ls_req_write  in  1  1 = store, 0 = load
ls_req_addr  in  XLEN  load/store address
ls_req_wdata  in  XLEN  store data
ls_resp_valid  out  1  one-cycle LS response pulse
ls_resp_rdata  out  XLEN  load data; 0 for stores
ls_resp_err  out  1  LS access timed out
mem_addr_valid  out  1  memory transaction active
mem_addr  out  XLEN  memory address
mem_data_valid  out  1  transaction is a write
mem_data  out  XLEN  write data
mem_ready  in  1  memory completes the transaction this cycle
mem_input  in  XLEN  read data, valid while mem_ready=1
busy  out  1  state == BUSY (debug)

Behaviour:
- States: IDLE, BUSY.
- Reset values:
  - state = IDLE; all mem_*, *_resp_* and busy = 0.
  - Round-robin pointer = "IF last granted", so LS wins the first tie.
  - Timeout counter = 0.
- Reset asserted mid-transaction aborts it silently. No response is issued. Memory outputs drop on the next edge.
- IDLE, grant selection:
  - If exactly one requester is valid, it wins.
  - If both are valid, ARB_MODE=0 picks the one not last granted; ARB_MODE=1 picks LS.
  - Only the winner's *_req_ready is asserted, and only in IDLE.
  - The pointer updates only on an actual grant.
- IDLE, on the accept edge:
  - Latch addr, write flag and wdata (IF write flag = 0).
  - mem_addr_valid <= 1; mem_data_valid <= write; mem_addr/mem_data <= latched values.
  - Go to BUSY; counter <= 0.
- In BUSY:
  - *_req_ready = 0 for both requesters.
  - mem_* outputs hold constant until completion.
  - mem_ready in IDLE is ignored.
- BUSY, completion edge (mem_ready=1):
  - Granted *_resp_valid <= 1 for exactly one cycle.
  - rdata <= mem_input for reads, 0 for writes; err <= 0.
  - mem_addr_valid <= 0; mem_data_valid <= 0; go to IDLE.
- BUSY, timeout (TIMEOUT_CYCLES≠0):
  - Counter increments each BUSY cycle without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 with mem_ready=0: resp_valid <= 1, err <= 1, rdata <= 0, drop mem_* valids, go to IDLE.
  - mem_ready in the same cycle as expiry counts as normal completion.
- Latency and throughput:
  - Accept at cycle N; mem_addr_valid high from N+1.
  - mem_ready at cycle M gives resp_valid at M+1, and a new accept is possible at M+1.
  - Peak throughput is one transaction per 2 cycles.
- Addresses are forwarded unmodified; no alignment checks.
- Requesters need not hold req after acceptance. Responses are never back-pressured.
- The counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1, and it must never wrap.

Decomposition:
- Shared package crab_pkg holds:
  - XLEN localparam;
  - typedef enum {ARB_IDLE, ARB_BUSY} arb_state_e;
  - typedef enum {GNT_IF, GNT_LS} grant_e;
  - ARB_RR / ARB_LS_PRIO constants.
- One sub-module is natural: crab_rr_arbiter2. It is a 2-way picker with pointer register, inputs req[1:0], mode and advance, outputs grant one-hot. It is reused later for the register-file write port.

Test Plan:
- Reset, then IF read: if_req_addr=0x100, mem_ready 2 cycles after mem_addr_valid with mem_input=0xDEADBEEF → mem_addr=0x100, mem_data_valid=0; if_resp_valid one pulse with rdata=0xDEADBEEF, err=0.
- LS store: addr=0x2000, wdata=0x12345678, mem_ready immediately → mem_addr_valid=mem_data_valid=1, mem_data=0x12345678; ls_resp_valid with rdata=0.
- Both requesters valid continuously, ARB_MODE=0, mem_ready always 1 → grants alternate LS, IF, LS, IF; one accept every 2 cycles. With ARB_MODE=1 → LS granted every time and IF starves.
- TIMEOUT_CYCLES=4, mem_ready held low → response after 4 BUSY cycles with err=1, rdata=0; mem_addr_valid=0 the next cycle. Repeat with mem_ready asserted in the 4th cycle → err=0.
- Reset asserted during BUSY → no resp_valid; all outputs 0 on the next edge; the first grant after reset goes to LS when both request.

Source files
------------

// File: rtl/crab_pkg.sv
// Shared types and constants for the crab core memory-side blocks.
package crab_pkg;

   localparam int XLEN        = 32;
   localparam int ARB_RR      = 0;
   localparam int ARB_LS_PRIO = 1;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
   typedef enum logic {GNT_IF, GNT_LS} grant_e;

endpackage

// File: rtl/crab_rr_arbiter2.sv
// Two-way request picker: round-robin or fixed priority to req[1].
// Bit 0 is IF and bit 1 is LS when used by the memory arbiter.
module crab_rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       mode,
   input  logic       advance,
   output logic [1:0] grant
);
   import crab_pkg::*;

   grant_e last_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= GNT_IF;
      end else if (advance && (grant != 2'b00)) begin
         last_q <= grant[1] ? GNT_LS : GNT_IF;
      end
   end

   // Tie goes to whichever side was not granted last, unless mode forces req[1].
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (mode || (last_q == GNT_IF)) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/crab_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store,
// one transaction at a time, with a watchdog that turns a stall into an error.
module crab_mem_arbiter #(
   parameter int XLEN           = crab_pkg::XLEN,
   parameter int ARB_MODE       = crab_pkg::ARB_RR,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req_valid,
   output logic            if_req_ready,
   input  logic [XLEN-1:0] if_req_addr,
   output logic            if_resp_valid,
   output logic [XLEN-1:0] if_resp_rdata,
   output logic            if_resp_err,
   input  logic            ls_req_valid,
   output logic            ls_req_ready,
   input  logic            ls_req_write,
   input  logic [XLEN-1:0] ls_req_addr,
   input  logic [XLEN-1:0] ls_req_wdata,
   output logic            ls_resp_valid,
   output logic [XLEN-1:0] ls_resp_rdata,
   output logic            ls_resp_err,
   output logic            mem_addr_valid,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_data_valid,
   output logic [XLEN-1:0] mem_data,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_input,
   output logic            busy
);
   import crab_pkg::*;

   localparam int            CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit            WDOG_EN  = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   arb_state_e      state_q, state_d;
   grant_e          gnt_q, gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      grant;
   logic            idle;
   logic            mav_d, mdv_d;
   logic [XLEN-1:0] maddr_d, mdata_d;
   logic            if_rv_d, if_err_d, ls_rv_d, ls_err_d;
   logic [XLEN-1:0] if_rdata_d, ls_rdata_d;
   logic            expired;
   logic            resp_err;
   logic [XLEN-1:0] resp_rdata;

   assign idle = (state_q == ARB_IDLE);
   assign busy = (state_q == ARB_BUSY);

   crab_rr_arbiter2 u_pick (
      .clk     (clk),
      .reset   (reset),
      .req     ({ls_req_valid, if_req_valid}),
      .mode    (ARB_MODE == ARB_LS_PRIO),
      .advance (idle),
      .grant   (grant)
   );

   assign if_req_ready = idle & grant[0];
   assign ls_req_ready = idle & grant[1];

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;
      mav_d      = mem_addr_valid;
      mdv_d      = mem_data_valid;
      maddr_d    = mem_addr;
      mdata_d    = mem_data;
      if_rv_d    = 1'b0;
      ls_rv_d    = 1'b0;
      if_rdata_d = if_resp_rdata;
      if_err_d   = if_resp_err;
      ls_rdata_d = ls_resp_rdata;
      ls_err_d   = ls_resp_err;
      expired    = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;

      if (state_q == ARB_IDLE) begin
         if (grant != 2'b00) begin
            state_d = ARB_BUSY;
            cnt_d   = '0;
            mav_d   = 1'b1;
            if (grant[1]) begin
               gnt_d   = GNT_LS;
               maddr_d = ls_req_addr;
               mdv_d   = ls_req_write;
               mdata_d = ls_req_wdata;
            end else begin
               gnt_d   = GNT_IF;
               maddr_d = if_req_addr;
               mdv_d   = 1'b0;
               mdata_d = '0;
            end
         end
      end else begin
         // mem_ready wins over a simultaneous watchdog expiry.
         expired = WDOG_EN && !mem_ready && (cnt_q == CNT_LAST);
         if (mem_ready || expired) begin
            state_d    = ARB_IDLE;
            mav_d      = 1'b0;
            mdv_d      = 1'b0;
            resp_err   = !mem_ready;
            resp_rdata = (mem_ready && !mem_data_valid) ? mem_input : '0;
            if (gnt_q == GNT_LS) begin
               ls_rv_d    = 1'b1;
               ls_rdata_d = resp_rdata;
               ls_err_d   = resp_err;
            end else begin
               if_rv_d    = 1'b1;
               if_rdata_d = resp_rdata;
               if_err_d   = resp_err;
            end
         end else if (WDOG_EN) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ARB_IDLE;
         gnt_q          <= GNT_IF;
         cnt_q          <= '0;
         mem_addr_valid <= 1'b0;
         mem_data_valid <= 1'b0;
         mem_addr       <= '0;
         mem_data       <= '0;
         if_resp_valid  <= 1'b0;
         if_resp_rdata  <= '0;
         if_resp_err    <= 1'b0;
         ls_resp_valid  <= 1'b0;
         ls_resp_rdata  <= '0;
         ls_resp_err    <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_q          <= gnt_d;
         cnt_q          <= cnt_d;
         mem_addr_valid <= mav_d;
         mem_data_valid <= mdv_d;
         mem_addr       <= maddr_d;
         mem_data       <= mdata_d;
         if_resp_valid  <= if_rv_d;
         if_resp_rdata  <= if_rdata_d;
         if_resp_err    <= if_err_d;
         ls_resp_valid  <= ls_rv_d;
         ls_resp_rdata  <= ls_rdata_d;
         ls_resp_err    <= ls_err_d;
      end
   end

endmodule
